// File: rtl/seg7_count_monitor.sv
// Monitor for an active-low 7-segment bus: glitch filter, hex decode, step and direction tracking.
// Optional stall timer and `stalled` output when SEG7_MON_STALL_EN is defined.
module seg7_count_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 8,
  parameter int STALL_CYCLES  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:6]       seg_in,
  input  logic             clear,
  output logic [3:0]       value_out,
  output logic             value_valid,
  output logic             new_value,
  output logic             dir_up,
  output logic [CNT_W-1:0] step_count,
  output logic             step_err,
  output logic             invalid_err
`ifdef SEG7_MON_STALL_EN
  ,
  output logic             stalled
`endif
);

  localparam logic [3:0] STAB_N   = 4'(STABLE_CYCLES);
  localparam logic [3:0] STAB_ACC = 4'(STABLE_CYCLES - 1);
  localparam logic [0:6] BLANK    = 7'b1111111;

  // Returns {legal, digit}; legal=0 covers both blank and undecodable patterns.
  function automatic logic [4:0] seg_decode(input logic [0:6] p);
    case (p)
      7'b0000001: return {1'b1, 4'h0};
      7'b1001111: return {1'b1, 4'h1};
      7'b0010010: return {1'b1, 4'h2};
      7'b0000110: return {1'b1, 4'h3};
      7'b1001100: return {1'b1, 4'h4};
      7'b0100100: return {1'b1, 4'h5};
      7'b0100000: return {1'b1, 4'h6};
      7'b0001111: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0000100: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b1100000: return {1'b1, 4'hB};
      7'b0110001: return {1'b1, 4'hC};
      7'b1000010: return {1'b1, 4'hD};
      7'b0110000: return {1'b1, 4'hE};
      7'b0111000: return {1'b1, 4'hF};
      default:    return 5'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    if (en && (c != {CNT_W{1'b1}})) return c + 1'b1;
    return c;
  endfunction

  // Stage p0: stability filter on the raw bus
  logic [0:6] cand_p0;
  logic [3:0] stab_cnt_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_p0     <= BLANK;
      stab_cnt_p0 <= 4'd0;
    end else if (seg_in != cand_p0) begin
      cand_p0     <= seg_in;
      stab_cnt_p0 <= 4'd1;
    end else if (stab_cnt_p0 < STAB_N) begin
      stab_cnt_p0 <= stab_cnt_p0 + 4'd1;
    end
  end

  logic       accept;
  logic [4:0] dec;
  logic       is_blank;
  logic [3:0] diff;
  logic       legal_acc;
  logic       changed;
  logic       good_step;
  logic       bad_step;
  logic       have_prev;

  assign accept    = (seg_in == cand_p0) && (stab_cnt_p0 == STAB_ACC);
  assign dec       = seg_decode(seg_in);
  assign is_blank  = (seg_in == BLANK);
  assign diff      = dec[3:0] - value_out;
  assign legal_acc = accept && dec[4];
  assign changed   = legal_acc && (!have_prev || (dec[3:0] != value_out));
  assign good_step = legal_acc && have_prev && ((diff == 4'd1) || (diff == 4'd15));
  assign bad_step  = legal_acc && have_prev && (diff != 4'd0) && !good_step;

  // Stage p1: decoded value, direction and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_out   <= 4'd0;
      value_valid <= 1'b0;
      new_value   <= 1'b0;
      dir_up      <= 1'b0;
      step_count  <= '0;
      step_err    <= 1'b0;
      invalid_err <= 1'b0;
      have_prev   <= 1'b0;
    end else begin
      new_value   <= changed;
      step_count  <= sat_inc(clear ? '0 : step_count, good_step);
      step_err    <= (step_err & ~clear) | bad_step;
      invalid_err <= (invalid_err & ~clear) | (accept & ~dec[4] & ~is_blank);
      if (good_step) dir_up <= (diff == 4'd1);
      if (accept) begin
        if (dec[4]) begin
          value_out   <= dec[3:0];
          value_valid <= 1'b1;
          have_prev   <= 1'b1;
        end else begin
          value_valid <= 1'b0;
          have_prev   <= 1'b0;
        end
      end
    end
  end

`ifdef SEG7_MON_STALL_EN
  localparam int TMR_W = $clog2(STALL_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(STALL_CYCLES);

  logic [TMR_W-1:0] stall_tmr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_tmr <= '0;
    end else if (changed || !value_valid) begin
      stall_tmr <= '0;
    end else if (stall_tmr != TMR_MAX) begin
      stall_tmr <= stall_tmr + 1'b1;
    end
  end

  assign stalled = (stall_tmr == TMR_MAX);
`endif

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Randomized/directed bench for seg7_count_monitor against a sample-level behavioural model.
module tb_seg7_count_monitor;
  localparam int S    = 2;
  localparam int CW   = 8;
  localparam int STL  = 10;
  localparam logic [0:6] BLANK = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [0:6]    seg_in = 7'b1111111;
  logic          clear = 1'b0;
  logic [3:0]    value_out;
  logic          value_valid, new_value, dir_up, step_err, invalid_err;
  logic [CW-1:0] step_count;
`ifdef SEG7_MON_STALL_EN
  logic          stalled;
`endif

  always #5 clk = ~clk;

  seg7_count_monitor #(.STABLE_CYCLES(S), .CNT_W(CW), .STALL_CYCLES(STL)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clear(clear),
    .value_out(value_out), .value_valid(value_valid), .new_value(new_value),
    .dir_up(dir_up), .step_count(step_count), .step_err(step_err),
    .invalid_err(invalid_err)
`ifdef SEG7_MON_STALL_EN
    , .stalled(stalled)
`endif
  );

  logic [0:6] pat_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [0:6] m_last;
  int m_run, m_val, m_cnt, m_tmr;
  bit m_valid, m_new, m_dir, m_have, m_serr, m_ierr;

  function automatic int lookup(input logic [0:6] p);
    for (int i = 0; i < 16; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = BLANK; m_run = 0; m_val = 0; m_cnt = 0; m_tmr = 0;
    m_valid = 0; m_new = 0; m_dir = 0; m_have = 0; m_serr = 0; m_ierr = 0;
  endtask

  task automatic model_edge(input logic [0:6] s, input bit clr);
    bit acc, step, old_valid;
    int d, df;
    old_valid = m_valid;
    if (s == m_last) m_run++;
    else begin m_last = s; m_run = 1; end
    acc = (m_run == S);
    step = 0;
    m_new = 0;
    if (clr) begin m_cnt = 0; m_serr = 0; m_ierr = 0; end
    if (acc) begin
      d = lookup(s);
      if (d >= 0) begin
        m_new = !m_have || (d != m_val);
        if (m_have) begin
          df = (d - m_val + 16) % 16;
          if (df == 1) begin m_dir = 1; step = 1; end
          else if (df == 15) begin m_dir = 0; step = 1; end
          else if (df != 0) m_serr = 1;
        end
        m_val = d; m_valid = 1; m_have = 1;
      end else begin
        if (s != BLANK) m_ierr = 1;
        m_valid = 0; m_have = 0;
      end
    end
    if (step && m_cnt < (2**CW - 1)) m_cnt++;
    if ((acc && d >= 0 && m_new) || !old_valid) m_tmr = 0;
    else if (m_tmr < STL) m_tmr++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("value_out", 32'(value_out), 32'(m_val));
    chk("value_valid", 32'(value_valid), 32'(m_valid));
    chk("new_value", 32'(new_value), 32'(m_new));
    chk("dir_up", 32'(dir_up), 32'(m_dir));
    chk("step_count", 32'(step_count), 32'(m_cnt));
    chk("step_err", 32'(step_err), 32'(m_serr));
    chk("invalid_err", 32'(invalid_err), 32'(m_ierr));
`ifdef SEG7_MON_STALL_EN
    chk("stalled", 32'(stalled), 32'(m_tmr >= STL));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(seg_in, clear);
    #1 check_all();
  endtask

  task automatic show(input logic [0:6] p, input int n);
    seg_in = p;
    repeat (n) tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    int kind, hold, d;
    logic [0:6] p;
    model_reset();
    #2 check_all();
    #10 reset = 1'b1;

    // First value after reset, then a full upward wrap
    show(pat_tab[0], 3);
    chk("first_value", 32'(value_out), 32'd0);
    chk("first_valid", 32'(value_valid), 32'd1);
    for (int i = 1; i <= 16; i++) show(pat_tab[i % 16], 4);
    chk("up_count", 32'(step_count), 32'd16);
    chk("up_dir", 32'(dir_up), 32'd1);
    chk("up_err", 32'(step_err), 32'd0);

    // Up to 3, then down through the 0->F wrap
    for (int i = 1; i <= 3; i++) show(pat_tab[i], 4);
    for (int i = 2; i >= -1; i--) show(pat_tab[(i + 16) % 16], 4);
    chk("down_count", 32'(step_count), 32'd23);
    chk("down_dir", 32'(dir_up), 32'd0);
    chk("down_val", 32'(value_out), 32'hF);

    // Glitch at 2 is ignored; stable jump to 5 is an error
    for (int i = 0; i <= 2; i++) show(pat_tab[i], 4);
    show(pat_tab[5], 1);
    show(pat_tab[2], 4);
    chk("glitch_err", 32'(step_err), 32'd0);
    show(pat_tab[5], 4);
    chk("jump_err", 32'(step_err), 32'd1);
    show(pat_tab[6], 4);
    chk("jump_sticky", 32'(step_err), 32'd1);
    pulse_clear();
    chk("clr_err", 32'(step_err), 32'd0);
    chk("clr_cnt", 32'(step_count), 32'd0);

    // Invalid pattern, then a fresh first value, then blank
    show(7'b1111110, 3);
    chk("inv_err", 32'(invalid_err), 32'd1);
    chk("inv_valid", 32'(value_valid), 32'd0);
    show(pat_tab[3], 3);
    chk("after_inv_valid", 32'(value_valid), 32'd1);
    chk("after_inv_serr", 32'(step_err), 32'd0);
    pulse_clear();
    show(BLANK, 3);
    chk("blank_valid", 32'(value_valid), 32'd0);
    chk("blank_ierr", 32'(invalid_err), 32'd0);

    // clear coinciding with a legal step: the step wins
    show(pat_tab[3], 3);
    seg_in = pat_tab[4];
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_vs_step", 32'(step_count), 32'd1);

    // Reset in the middle of qualifying a new pattern
    show(pat_tab[5], 1);
    reset = 1'b0;
    #1 model_reset();
    check_all();
    #1 reset = 1'b1;
    show(pat_tab[5], 3);
    chk("post_rst_val", 32'(value_out), 32'd5);
    chk("post_rst_cnt", 32'(step_count), 32'd0);

`ifdef SEG7_MON_STALL_EN
    show(pat_tab[6], 3);
    show(pat_tab[7], 20);
    chk("stall_set", 32'(stalled), 32'd1);
    show(pat_tab[8], 2);
    chk("stall_clr", 32'(stalled), 32'd0);
`endif

    // Saturation of step_count
    pulse_clear();
    d = m_val;
    for (int i = 0; i < 260; i++) begin
      d = (d + 1) % 16;
      show(pat_tab[d], 2);
    end
    chk("sat_count", 32'(step_count), 32'hFF);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 4);
      if (kind <= 5) p = pat_tab[(m_val + (kind[0] ? 1 : 15)) % 16];
      else if (kind == 6) p = pat_tab[$urandom_range(0, 15)];
      else if (kind == 7) p = BLANK;
      else p = 7'($urandom);
      seg_in = p;
      for (int k = 0; k < hold; k++) begin
        clear = ($urandom_range(0, 15) == 0);
        tick();
      end
      clear = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
